keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scan controller for the 4x4 matrix keypad. Drives one column low at a time and samples the rows.
//  Debounces each press and decodes it into one-cycle keydown pulses plus a digit value for the countdown logic.
//  Runs directly on the 100 MHz clk. An internal tick divider replaces the external keypad clock divider.
// PARAMETERS
//  SCAN_DIV      100000  clk cycles per scan tick (1 ms at 100 MHz); legal range >= 2
//  DEBOUNCE_CNT  20      consecutive stable ticks needed to accept a press or a release; legal range >= 1
// PORTS
//  clk              in   1  system clock, 100 MHz
//  rst_n            in   1  asynchronous, active-low reset
//  row_1..row_4     in   1  keypad rows, active-low, externally pulled up, asynchronous
//  col_1..col_4     out  1  keypad column drives, active-low, exactly one low at any time
//  keydown_num      out  1  one-clk pulse: digit key accepted
//  keydown_start    out  1  one-clk pulse: START key accepted
//  keydown_confirm  out  1  one-clk pulse: CONFIRM key accepted
//  keydown_clear    out  1  one-clk pulse: CLEAR key accepted
//  num              out  4  last accepted digit, 0..9; held between presses
//  key_held         out  1  level: a press has been accepted and not yet released
// BEHAVIOUR
//  Reset values: col_1=0, col_2..col_4=1, all pulses=0, num=0, key_held=0, state=SCAN, counters=0.
//  Rows pass through a 2-flop synchronizer. All decisions use the synchronized rows (2-clk input latency).
//  Tick: counter runs 0..SCAN_DIV-1 and wraps. tick=1 for the single clk where counter==SCAN_DIV-1.
//  Key map, (row,col) 1-based:
//   r1: 1 2 3 START
//   r2: 4 5 6 CONFIRM
//   r3: 7 8 9 CLEAR
//   r4: * 0 # D
//   *, # and D are unmapped. They are debounced and held like any other key but produce no pulse.
//  State machine (state advances only on tick):
//   SCAN: sample the rows for the current column.
//    - Exactly one row low: latch row and column, set deb_cnt=1, go to DEBOUNCE. Column drive is frozen.
//    - No row low, or more than one row low: advance the column 1->2->3->4->1.
//   DEBOUNCE: latched row still low -> deb_cnt++.
//    - When deb_cnt reaches DEBOUNCE_CNT, go to HELD and emit the mapped pulse.
//    - Latched row high -> go to SCAN and advance the column. No pulse.
//    - With DEBOUNCE_CNT=1, the SCAN detection tick itself completes debounce.
//   HELD: key_held=1, column drive stays frozen.
//    - Each tick with the latched row high -> rel_cnt++. A tick with it low -> rel_cnt=0.
//    - When rel_cnt reaches DEBOUNCE_CNT: go to SCAN, advance the column, key_held=0.
//  Pulses are high for exactly one clk, the clk after the accepting tick.
//  - At most one pulse per press. No auto-repeat.
//  - On a digit press, num updates in the same clk that keydown_num rises.
//  - START, CONFIRM and CLEAR leave num unchanged.
//  Other keys pressed while in DEBOUNCE or HELD are ignored; only the latched row is watched.
//  A key held through reset is re-detected after reset and produces a fresh pulse.
//  Reset mid-operation abandons any debounce or hold immediately. No pulse is emitted.
//  Column outputs are registered; they change only on the clk after a tick.
// TESTING (bench params SCAN_DIV=4, DEBOUNCE_CNT=3)
//  1. Hold r1 low while col_2 is low for 10 ticks -> one keydown_num pulse, num=2, key_held=1.
//     Release for 3 ticks -> key_held=0, scanning resumes at col_3.
//  2. r2 low on col_1 for 2 ticks, then high -> no pulse. SCAN resumes at col_2.
//  3. Hold r3 on col_4 with num=5 -> one keydown_clear pulse, num stays 5.
//     Then r1 on col_4 -> one keydown_start pulse.
//  4. r1 and r2 both low on col_3 -> no pulse, column keeps rotating.
//     Single r4 on col_2 -> keydown_num pulse with num=0.
//  5. Hold r4 on col_1 (*) -> key_held=1 and no pulse of any kind.
//  6. Assert rst_n=0 during HELD -> col=1110, all pulses 0, key_held=0 asynchronously.
//     After release with the key still held -> exactly one new pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning controller for a 4x4 active-low matrix keypad.
// A free-running divider paces the scan. Each press is debounced and then held
// until a debounced release. A press produces at most one decoded one-clk pulse.
module keypad_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       row_1,
    input  logic       row_2,
    input  logic       row_3,
    input  logic       row_4,
    output logic       col_1,
    output logic       col_2,
    output logic       col_3,
    output logic       col_4,
    output logic       keydown_num,
    output logic       keydown_start,
    output logic       keydown_confirm,
    output logic       keydown_clear,
    output logic [3:0] num,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_DIGIT,
        KEY_START,
        KEY_CONFIRM,
        KEY_CLEAR
    } key_kind_e;

    // Key classification from the 0-based (row, col) position.
    function automatic key_kind_e key_kind(input logic [1:0] r, input logic [1:0] c);
        key_kind_e k;
        k = KEY_NONE;
        if (c == 2'd3) begin
            case (r)
                2'd0:    k = KEY_START;
                2'd1:    k = KEY_CONFIRM;
                2'd2:    k = KEY_CLEAR;
                default: k = KEY_NONE;
            endcase
        end else if (r != 2'd3) begin
            k = KEY_DIGIT;
        end else if (c == 2'd1) begin
            k = KEY_DIGIT;
        end
        return k;
    endfunction

    // Digit value of a digit key: rows 1..3 hold 1..9, the bottom row holds 0.
    function automatic logic [3:0] key_digit(input logic [1:0] r, input logic [1:0] c);
        int v;
        if (r == 2'd3) v = 0;
        else           v = int'(r) * 3 + int'(c) + 1;
        return 4'(v);
    endfunction

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [3:0]       rows_low;
    logic             one_low;
    logic [1:0]       row_enc;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    state_e           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_n_q;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [DEB_W-1:0] rel_cnt_q, rel_cnt_d;
    logic             accept;
    key_kind_e        accept_kind;
    logic [3:0]       accept_digit;

    logic             pulse_num_q, pulse_start_q, pulse_confirm_q, pulse_clear_q;
    logic [3:0]       num_q;

    // Two-flop synchronizer for the asynchronous rows; idle (pulled-up) after reset.
    // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= {row_4, row_3, row_2, row_1};
            row_sync <= row_meta;
        end
    end

    // Scan tick divider: wraps at SCAN_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                     div_cnt <= div_cnt + DIV_W'(1);
    end

    assign tick     = (div_cnt == DIV_LAST);
    assign rows_low = ~row_sync;
    assign one_low  = $onehot(rows_low);

    // Encode the single low row (only used when exactly one row is low).
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        row_enc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rows_low[i]) row_enc = 2'(i);
        end
    end

    // Next-state logic: scan, debounce a candidate, hold until a debounced release.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        deb_cnt_d = deb_cnt_q;
        rel_cnt_d = rel_cnt_q;
        accept    = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (one_low) begin
                        row_idx_d = row_enc;
                        deb_cnt_d = DEB_ONE;
                        if (DEB_ONE == DEB_DONE) begin
                            state_d   = HELD;
                            rel_cnt_d = '0;
                            accept    = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_sync[row_idx_q]) begin
                        deb_cnt_d = deb_cnt_q + DEB_ONE;
                        if (deb_cnt_d == DEB_DONE) begin
                            state_d   = HELD;
                            rel_cnt_d = '0;
                            accept    = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                HELD: begin
                    if (row_sync[row_idx_q]) begin
                        rel_cnt_d = rel_cnt_q + DEB_ONE;
                        if (rel_cnt_d == DEB_DONE) begin
                            state_d   = SCAN;
                            rel_cnt_d = '0;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Decode of the key being accepted; the column is frozen, so col_idx_q is the key column.
    assign accept_kind  = key_kind(row_idx_d, col_idx_q);
    assign accept_digit = key_digit(row_idx_d, col_idx_q);

    // FSM, counters and registered column drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            col_n_q   <= 4'b1110;
            row_idx_q <= 2'd0;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            col_n_q   <= ~(4'b0001 << col_idx_d);
            row_idx_q <= row_idx_d;
            deb_cnt_q <= deb_cnt_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    // One-clk keydown pulses and the held digit value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_num_q     <= 1'b0;
            pulse_start_q   <= 1'b0;
            pulse_confirm_q <= 1'b0;
            pulse_clear_q   <= 1'b0;
            num_q           <= 4'd0;
        end else begin
            pulse_num_q     <= accept && (accept_kind == KEY_DIGIT);
            pulse_start_q   <= accept && (accept_kind == KEY_START);
            pulse_confirm_q <= accept && (accept_kind == KEY_CONFIRM);
            pulse_clear_q   <= accept && (accept_kind == KEY_CLEAR);
            if (accept && (accept_kind == KEY_DIGIT)) num_q <= accept_digit;
        end
    end

    assign col_1           = col_n_q[0];
    assign col_2           = col_n_q[1];
    assign col_3           = col_n_q[2];
    assign col_4           = col_n_q[3];
    assign keydown_num     = pulse_num_q;
    assign keydown_start   = pulse_start_q;
    assign keydown_confirm = pulse_confirm_q;
    assign keydown_clear   = pulse_clear_q;
    assign num             = num_q;
    assign key_held        = (state_q == HELD);

endmodule
